// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: bundles the redirect, instruction-memory and decode-side handshake signals of
// the instruction fetch unit.
//
// Signals
//   redirect_i      load new PC this cycle, flushes fetch state
//   redirect_pc_i   redirect target (bits [1:0] are dropped by the fetch unit)
//   imem_req_o      fetch request valid
//   imem_addr_o     fetch address (the fetch unit's pc)
//   imem_gnt_i      request accepted this cycle
//   imem_rvalid_i   response data valid
//   imem_rdata_i    response instruction word
//   instr_valid_o   output buffer holds a valid instruction
//   instr_o         fetched instruction
//   pc_o            address of instr_o
//   instr_ready_i   downstream accepts the buffer this cycle
//   misalign_o      misaligned-redirect pulse
//
// Modports
//   master  the fetch unit
//   slave   the environment (memory, redirect source and decode stage)
interface ifetch_unit_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic        misalign_o;

  modport master (
    input  redirect_i,
    input  redirect_pc_i,
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    output instr_valid_o,
    output instr_o,
    output pc_o,
    input  instr_ready_i,
    output misalign_o
  );

  modport slave (
    output redirect_i,
    output redirect_pc_i,
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    input  instr_valid_o,
    input  instr_o,
    input  pc_o,
    output instr_ready_i,
    input  misalign_o
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: front-end instruction fetch unit. Owns the program counter, issues one outstanding
// request at a time to instruction memory (req/gnt/rvalid) and holds the fetched instruction and
// its PC in a one-entry output buffer for the decode register. Redirects from later stages load
// a new PC and cause any in-flight response to be dropped.
//
// Parameters
//   RESET_PC  first PC fetched after reset
//
// Ports
//   clk   pipeline clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   ifetch_unit_if.master (redirect, imem handshake, output buffer, misalign flag)
//
// Optional feature
//   IFETCH_MISALIGN_CHK_EN  when defined, a redirect whose target has nonzero bits [1:0] pulses
//                           misalign_o for the following cycle. When undefined misalign_o is 0.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq,   // ready to issue a request for pc
    StWait,  // request granted, waiting for its response
    StDrop   // response still owed to a flushed request, discard it
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        misalign_q, misalign_d;

  logic        buf_free;
  logic        req;
  logic [31:0] redirect_target;

  // The buffer can take a new instruction if it is empty or being drained this cycle.
  assign buf_free        = !valid_q || bus.instr_ready_i;
  // Only request when the response is guaranteed a free slot, so S_WAIT never has to stall.
  assign req             = (state_q == StReq) && buf_free && !bus.redirect_i;
  assign redirect_target = {bus.redirect_pc_i[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    out_pc_d   = out_pc_q;
    // A consume clears the buffer unless a response reloads it below.
    valid_d    = valid_q && !bus.instr_ready_i;

    if (bus.redirect_i) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      unique case (state_q)
        StReq:   state_d = StReq;
        StWait:  state_d = bus.imem_rvalid_i ? StReq : StDrop;
        StDrop:  state_d = bus.imem_rvalid_i ? StReq : StDrop;
        default: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (req && bus.imem_gnt_i) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (bus.imem_rvalid_i) begin
            instr_d  = bus.imem_rdata_i;
            out_pc_d = fetch_pc_q;
            valid_d  = 1'b1;
            state_d  = StReq;
          end
        end
        StDrop: begin
          if (bus.imem_rvalid_i) begin
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  assign misalign_d = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
`else
  assign misalign_d = 1'b0;
  // Low target bits are dropped silently in this build.
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^bus.redirect_pc_i[1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NopInstr;
      out_pc_q   <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      out_pc_q   <= out_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = out_pc_q;
  assign bus.misalign_o    = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit. A memory model answers granted requests after a random
// latency; a reference model tracks the expected fetch stream (sequential PCs, restarted at each
// redirect, responses to pre-redirect requests dropped) and pushes each instruction that must
// reach decode into a scoreboard queue. A separate monitor pops and compares on every consume.
module tb_ifetch_unit;
  localparam logic [31:0] ResetPc = 32'h0000_0100;
  localparam int unsigned NumCycles = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(ResetPc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
  endtask

  // Monitor: every accepted instruction must match the oldest expected entry.
  int unsigned consumed = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pc_o", bus.pc_o, e.pc);
          check("instr_o", bus.instr_o, e.instr);
          consumed++;
        end
      end
    end
  end

  // Memory model state
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int unsigned mem_lat = 0;
  logic        gnt_seen = 1'b0;
  int unsigned stall = 0;

  // Reference model state
  logic [31:0] exp_pc;
  logic        live;
  logic [31:0] live_pc;
  logic        prev_mis;
  logic        prev_hold;
  logic [31:0] prev_instr, prev_pc;

  function automatic logic [31:0] pick_target();
    unique case ($urandom % 5)
      0: return 32'h0000_0200;
      1: return 32'h0000_0302;
      2: return 32'hFFFF_FFFC;
      3: return 32'hFFFF_FFF9;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.instr_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    check("rst_instr", bus.instr_o, 32'h0000_0013);
    check("rst_pc_o", bus.pc_o, 32'd0);
    check("rst_misalign", {31'd0, bus.misalign_o}, 32'd0);
    check("rst_req", {31'd0, bus.imem_req_o}, 32'd1);
    check("rst_addr", bus.imem_addr_o, ResetPc);
    exp_pc    = ResetPc;
    live      = 1'b0;
    live_pc   = '0;
    prev_mis  = 1'b0;
    prev_hold = 1'b0;
    prev_instr = '0;
    prev_pc    = '0;

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(posedge clk);
      #1;
      // Memory: register last cycle's grant, then possibly respond.
      if (gnt_seen) begin
        mem_busy = 1'b1;
        mem_addr = bus.imem_addr_o;
        mem_lat  = (cyc < 20) ? 0 : $urandom_range(0, 3);
      end
      bus.imem_rvalid_i = 1'b0;
      if (mem_busy) begin
        if (mem_lat == 0) begin
          bus.imem_rvalid_i = 1'b1;
          bus.imem_rdata_i  = (($urandom % 8) == 0) ? 32'hDEAD_BEEF : $urandom;
          mem_busy = 1'b0;
        end else begin
          mem_lat--;
        end
      end
      // Stimulus: zero-wait, always-ready warmup, then random traffic with stall bursts.
      if (cyc < 20) begin
        bus.imem_gnt_i    = 1'b1;
        bus.instr_ready_i = 1'b1;
        bus.redirect_i    = 1'b0;
      end else begin
        bus.imem_gnt_i = ($urandom % 4) != 0;
        if (stall == 0 && ($urandom % 16) == 0) stall = 5;
        if (stall > 0) begin
          bus.instr_ready_i = 1'b0;
          stall--;
        end else begin
          bus.instr_ready_i = ($urandom % 8) != 0;
        end
        bus.redirect_i    = ($urandom % 10) == 0;
        bus.redirect_pc_i = pick_target();
      end

      @(negedge clk);
      #1;
      // Outputs observable this cycle
      check("imem_addr", bus.imem_addr_o, exp_pc);
`ifdef IFETCH_MISALIGN_CHK_EN
      check("misalign", {31'd0, bus.misalign_o}, {31'd0, prev_mis});
`else
      check("misalign", {31'd0, bus.misalign_o}, 32'd0);
`endif
      if (bus.imem_req_o) check("one_outstanding", {31'd0, mem_busy}, 32'd0);
      if (bus.instr_valid_o && !bus.instr_ready_i)
        check("req_while_full", {31'd0, bus.imem_req_o}, 32'd0);
      if (prev_hold) begin
        check("hold_valid", {31'd0, bus.instr_valid_o}, 32'd1);
        check("hold_instr", bus.instr_o, prev_instr);
        check("hold_pc", bus.pc_o, prev_pc);
      end

      // Reference model update for the coming edge
      if (bus.imem_rvalid_i && !bus.redirect_i && live) begin
        exp_q.push_back('{pc: live_pc, instr: bus.imem_rdata_i});
      end
      if (bus.imem_rvalid_i) live = 1'b0;
      gnt_seen = bus.imem_req_o && bus.imem_gnt_i;
      if (bus.redirect_i) begin
        exp_q.delete();
        live   = 1'b0;
        exp_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
      end else if (gnt_seen) begin
        live    = 1'b1;
        live_pc = exp_pc;
        exp_pc  = exp_pc + 32'd4;
      end
      prev_mis   = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
      prev_hold  = bus.instr_valid_o && !bus.instr_ready_i && !bus.redirect_i;
      prev_instr = bus.instr_o;
      prev_pc    = bus.pc_o;
    end

    check("progress", {31'd0, consumed > 200}, 32'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Front-end instruction fetch unit at the head of the 5-stage pipeline. It owns the program counter, issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake, and presents fetched instructions with their PC to the q1 decode register. It is the consuming end of the write-back-to-fetch path: it takes redirects resolved in later stages and discards stale in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- redirect_i  input  1  load new PC this cycle; flushes fetch state
- redirect_pc_i  input  32  redirect target
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  32  fetch address; always equals internal pc
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response data valid
- imem_rdata_i  input  32  response instruction word
- instr_valid_o  output  1  output buffer holds a valid instruction
- instr_o  output  32  fetched instruction
- pc_o  output  32  address of instr_o
- instr_ready_i  input  1  downstream accepts buffer this cycle
- misalign_o  output  1  misaligned redirect flag (see Configuration)

## Operation
- State: pc (32b), fetch_pc (32b, address of in-flight request), 1-entry output buffer {instr_valid_o, instr_o, pc_o}, FSM {S_REQ, S_WAIT, S_DROP}.
- Buffer "free" = !instr_valid_o || instr_ready_i. Consume = instr_valid_o && instr_ready_i; clears instr_valid_o next cycle unless reloaded.
- imem_req_o = (state == S_REQ) && free && !redirect_i. Combinational.
- S_REQ: on imem_req_o && imem_gnt_i: fetch_pc <= pc, pc <= pc + 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), go S_WAIT. Otherwise hold.
- S_WAIT: on imem_rvalid_i: instr_o <= imem_rdata_i, pc_o <= fetch_pc, instr_valid_o <= 1, go S_REQ. Buffer is guaranteed free (request only issued when free).
- S_DROP: on imem_rvalid_i: discard data, go S_REQ.
- imem_rvalid_i outside S_WAIT/S_DROP is ignored.
- Redirect (highest priority, any state): pc <= redirect_pc_i with bits [1:0] cleared, instr_valid_o <= 0, instr_o/pc_o hold.
  - S_REQ: stay S_REQ (imem_req_o suppressed that cycle, so nothing is granted).
  - S_WAIT without rvalid: go S_DROP. S_WAIT with rvalid same cycle: response discarded, go S_REQ.
  - S_DROP without rvalid: stay S_DROP. S_DROP with rvalid: go S_REQ.
- Redirect and consume in same cycle: redirect wins; buffer cleared.

## Timing
- Reset (rst high at edge): pc = RESET_PC, state = S_REQ, instr_valid_o = 0, instr_o = 32'h0000_0013 (NOP), pc_o = 0, misalign_o = 0. imem_req_o = 1 in the first cycle after rst deasserts.
- rst asserted mid-fetch: outstanding response after reset is ignored (state S_REQ). Memory side must not return rvalid for pre-reset grants after the reset cycle.
- Latency: gnt at cycle N, rvalid at N+k -> instr_valid_o at N+k+1.
- Zero-wait memory (gnt same cycle, rvalid next cycle), always-ready downstream: one instruction per 2 cycles.
- Redirect at cycle N -> imem_addr_o = target at N+1. First request at N+1 only if the FSM is in S_REQ; otherwise after the stale rvalid.
- At most one request outstanding at all times.

## Configuration
- IFETCH_MISALIGN_CHK_EN defined: a redirect with redirect_pc_i[1:0] != 0 pulses misalign_o high for exactly the cycle after the redirect. The PC is still aligned down, and fetch continues.
- Not defined: misalign_o is tied to 0. Bits [1:0] of the target are cleared silently.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory, ready=1 -> imem_addr_o sequence 0x100, 0x104, 0x108. instr_valid_o/pc_o pulse every 2 cycles with matching rdata. Before the first response, instr_o=0x00000013.
- Downstream stall: instr_ready_i=0 for 5 cycles after the first valid -> imem_req_o stays 0, instr_o/pc_o stable. Ready returns -> next request on the same cycle.
- Redirect to 0x200 while in S_WAIT; rvalid arrives 3 cycles later with 0xDEADBEEF -> that word is never presented. Next imem_addr_o = 0x200.
- Redirect on the same cycle as rvalid -> response discarded, instr_valid_o=0 next cycle, request to target the following cycle.
- PC wrap: RESET_PC=0xFFFF_FFFC -> second request address 0x0000_0000.
- With IFETCH_MISALIGN_CHK_EN, redirect to 0x302 -> misalign_o=1 for one cycle, imem_addr_o=0x300. Without the macro, misalign_o stays 0 and the address is the same.
